result_checker: RTL and testbench

- Parametrised, synthesizable self-checking block for CPU program runs. Replaces hand-written end-of-run displays with a sequential checker.
- After a start pulse it waits a configurable number of cycles for the program to finish.
- It then walks an expected-value table. Each entry is either a register-file check or a data-memory check. It reads the actual value through dedicated read ports.
- It reports per-check failures, a saturating error count and a final pass/fail. It sits beside the cpu instance in bench tops and FPGA bring-up wrappers.

---
 rtl/result_checker.sv | 157 +++++++++++++++
 tb/tb_result_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// Sequential end-of-run checker: waits WAIT_CYCLES after start, then walks an expected-value table
// against register-file / data-memory read ports. Optional: RESULT_CHECKER_HALT_ON_FAIL_EN.
module result_checker #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CHECKS  = 8,
  parameter int unsigned RF_ADDR_W   = 5,
  parameter int unsigned DM_ADDR_W   = 8,
  parameter int unsigned WAIT_CYCLES = 10,
  parameter int unsigned ERR_W       = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_CHECKS) + 1,
  localparam int unsigned ADDR_W     = (RF_ADDR_W > DM_ADDR_W) ? RF_ADDR_W : DM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  chk_idx,
  input  logic              chk_is_mem,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_value,
  output logic [RF_ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DM_ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual
);

  localparam int unsigned WCNT_W = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [2:0] {StIdle, StWait, StFetch, StCompare, StDone} state_e;

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      chk_idx_q, chk_idx_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [IDX_W-1:0]      fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0]     fail_actual_q, fail_actual_d;
  logic [RF_ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DM_ADDR_W-1:0]  dm_addr_q, dm_addr_d;
  logic                  is_mem_q, is_mem_d;
  logic [DATA_W-1:0]     exp_q, exp_d;
  logic [DATA_W-1:0]     actual;
  logic                  mismatch;
  logic                  last_entry;

  assign actual     = is_mem_q ? dm_data : rf_data;
  assign mismatch   = (actual != exp_q);
  assign last_entry = (chk_idx_q == IDX_W'(NUM_CHECKS - 1));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    chk_idx_d     = chk_idx_q;
    err_d         = err_q;
    fail_valid_d  = 1'b0;
    fail_idx_d    = fail_idx_q;
    fail_actual_d = fail_actual_q;
    rf_addr_d     = rf_addr_q;
    dm_addr_d     = dm_addr_q;
    is_mem_d      = is_mem_q;
    exp_d         = exp_q;
    case (state_q)
      StIdle, StDone: begin
        // A start in DONE restarts exactly like one in IDLE; results hold otherwise.
        if (start) begin
          state_d       = StWait;
          wait_cnt_d    = '0;
          chk_idx_d     = '0;
          err_d         = '0;
          fail_idx_d    = '0;
          fail_actual_d = '0;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1)) state_d = StFetch;
      end
      StFetch: begin
        rf_addr_d = chk_addr[RF_ADDR_W-1:0];
        dm_addr_d = chk_addr[DM_ADDR_W-1:0];
        is_mem_d  = chk_is_mem;
        exp_d     = chk_value;
        state_d   = StCompare;
      end
      StCompare: begin
        if (mismatch) begin
          fail_valid_d  = 1'b1;
          fail_idx_d    = chk_idx_q;
          fail_actual_d = actual;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end
`ifdef RESULT_CHECKER_HALT_ON_FAIL_EN
        if (mismatch || last_entry) begin
          state_d = StDone;
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
          state_d   = StFetch;
        end
`else
        if (last_entry) begin
          state_d = StDone;
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
          state_d   = StFetch;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      chk_idx_q     <= '0;
      err_q         <= '0;
      fail_valid_q  <= 1'b0;
      fail_idx_q    <= '0;
      fail_actual_q <= '0;
      rf_addr_q     <= '0;
      dm_addr_q     <= '0;
      is_mem_q      <= 1'b0;
      exp_q         <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      chk_idx_q     <= chk_idx_d;
      err_q         <= err_d;
      fail_valid_q  <= fail_valid_d;
      fail_idx_q    <= fail_idx_d;
      fail_actual_q <= fail_actual_d;
      rf_addr_q     <= rf_addr_d;
      dm_addr_q     <= dm_addr_d;
      is_mem_q      <= is_mem_d;
      exp_q         <= exp_d;
    end
  end

  assign chk_idx     = chk_idx_q;
  assign rf_addr     = rf_addr_q;
  assign dm_addr     = dm_addr_q;
  assign busy        = (state_q == StWait) || (state_q == StFetch) || (state_q == StCompare);
  assign done        = (state_q == StDone);
  assign pass        = done && (err_q == '0);
  assign err_count   = err_q;
  assign fail_valid  = fail_valid_q;
  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_actual_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: 5-entry table, WAIT_CYCLES=10, ERR_W=2.
module tb_result_checker;
  localparam int unsigned NC = 5;
  localparam int unsigned WC = 10;
  localparam int unsigned EW = 2;
`ifdef RESULT_CHECKER_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  chk_idx;
  logic        chk_is_mem;
  logic [7:0]  chk_addr;
  logic [31:0] chk_value;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [7:0]  dm_addr;
  logic [31:0] dm_data;
  logic        busy, done, pass, fail_valid;
  logic [EW-1:0] err_count;
  logic [3:0]  fail_idx;
  logic [31:0] fail_actual;

  logic        tbl_is_mem [NC];
  logic [7:0]  tbl_addr [NC];
  logic [31:0] tbl_val [NC];
  logic [31:0] rf [32];
  logic [31:0] dm [256];

  int checks = 0;
  int passed = 0;
  int lat, pulses, max_idx;
  bit first_busy, first_done;

  result_checker #(
    .DATA_W(32), .NUM_CHECKS(NC), .RF_ADDR_W(5), .DM_ADDR_W(8), .WAIT_CYCLES(WC), .ERR_W(EW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .chk_idx(chk_idx), .chk_is_mem(chk_is_mem),
    .chk_addr(chk_addr), .chk_value(chk_value), .rf_addr(rf_addr), .rf_data(rf_data),
    .dm_addr(dm_addr), .dm_data(dm_data), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_actual(fail_actual)
  );

  always #5 clock = ~clock;

  always_comb begin
    chk_is_mem = 1'b0;
    chk_addr   = '0;
    chk_value  = '0;
    if (int'(chk_idx) < NC) begin
      chk_is_mem = tbl_is_mem[int'(chk_idx)];
      chk_addr   = tbl_addr[int'(chk_idx)];
      chk_value  = tbl_val[int'(chk_idx)];
    end
  end

  assign rf_data = rf[rf_addr];
  assign dm_data = dm[dm_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    else passed++;
  endtask

  task automatic set_good_model();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 256; i++) dm[i] = '0;
    rf[3] = 32'd5;
    rf[4] = 32'd5;
    dm[1] = 32'd5;
  endtask

  // Pulses (or holds) start and runs until done, observing latency and fail pulses.
  task automatic do_run(input bit hold);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
    lat = 0;
    pulses = 0;
    max_idx = int'(chk_idx);
    first_busy = busy;
    first_done = done;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
      if (fail_valid) pulses++;
      if (int'(chk_idx) > max_idx) max_idx = int'(chk_idx);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_fail_valid", 32'(fail_valid), 0);
    chk("rst_chk_idx", 32'(chk_idx), 0);
    reset = 1'b1;
  endtask

  task automatic test_all_pass();
    set_good_model();
    do_run(1'b0);
    chk("pass_first_busy", 32'(first_busy), 1);
    chk("pass_first_done", 32'(first_done), 0);
    chk("pass_latency", lat, 20);
    chk("pass_pulses", pulses, 0);
    chk("pass_err", 32'(err_count), 0);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_busy", 32'(busy), 0);
    chk("pass_dm_addr", 32'(dm_addr), 1);
    chk("pass_chk_idx", 32'(chk_idx), 4);
    @(negedge clock);
    chk("pass_hold_done", 32'(done), 1);
    chk("pass_hold_fv", 32'(fail_valid), 0);
  endtask

  task automatic test_single_mismatch();
    set_good_model();
    rf[5] = 32'd7;
    do_run(1'b0);
    chk("one_latency", lat, HALT ? 16 : 20);
    chk("one_pulses", pulses, 1);
    chk("one_fail_idx", 32'(fail_idx), 2);
    chk("one_fail_actual", fail_actual, 7);
    chk("one_err", 32'(err_count), 1);
    chk("one_pass", 32'(pass), 0);
  endtask

  task automatic test_saturation();
    set_good_model();
    rf[3] = 32'd1;
    rf[4] = 32'd2;
    rf[5] = 32'd3;
    rf[6] = 32'd4;
    dm[1] = 32'd9;
    do_run(1'b0);
    chk("sat_latency", lat, HALT ? 12 : 20);
    chk("sat_pulses", pulses, HALT ? 1 : 5);
    chk("sat_err", 32'(err_count), HALT ? 1 : 3);
    chk("sat_fail_idx", 32'(fail_idx), HALT ? 0 : 4);
    chk("sat_fail_actual", fail_actual, HALT ? 1 : 9);
    chk("sat_pass", 32'(pass), 0);
  endtask

  task automatic test_reset_midrun();
    set_good_model();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    chk("mid_pre_idx", 32'(chk_idx), 2);
    chk("mid_pre_rf_addr", 32'(rf_addr), 4);
    #1 reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_chk_idx", 32'(chk_idx), 0);
    chk("mid_rf_addr", 32'(rf_addr), 0);
    chk("mid_dm_addr", 32'(dm_addr), 0);
    @(negedge clock);
    reset = 1'b1;
    do_run(1'b0);
    chk("mid_rerun_latency", lat, 20);
    chk("mid_rerun_pass", 32'(pass), 1);
  endtask

  task automatic test_start_held();
    int guard;
    set_good_model();
    rf[5] = 32'd7;
    do_run(1'b1);
    chk("held_latency", lat, HALT ? 16 : 20);
    chk("held_err", 32'(err_count), 1);
    @(negedge clock);
    chk("held_restart_done", 32'(done), 0);
    chk("held_restart_busy", 32'(busy), 1);
    chk("held_restart_err", 32'(err_count), 0);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("held_second_done", 32'(done), 1);
  endtask

  task automatic test_halt_entry1();
    set_good_model();
    rf[4] = 32'd3;
    do_run(1'b0);
    chk("halt_latency", lat, HALT ? 14 : 20);
    chk("halt_err", 32'(err_count), 1);
    chk("halt_fail_idx", 32'(fail_idx), 1);
    chk("halt_fail_actual", fail_actual, 3);
    chk("halt_max_idx", max_idx, HALT ? 1 : 4);
    chk("halt_pass", 32'(pass), 0);
  endtask

  initial begin
    tbl_is_mem[0] = 1'b0; tbl_addr[0] = 8'd3; tbl_val[0] = 32'd5;
    tbl_is_mem[1] = 1'b0; tbl_addr[1] = 8'd4; tbl_val[1] = 32'd5;
    tbl_is_mem[2] = 1'b0; tbl_addr[2] = 8'd5; tbl_val[2] = 32'd0;
    tbl_is_mem[3] = 1'b0; tbl_addr[3] = 8'd6; tbl_val[3] = 32'd0;
    tbl_is_mem[4] = 1'b1; tbl_addr[4] = 8'd1; tbl_val[4] = 32'd5;
    set_good_model();
    test_reset();
    test_all_pass();
    test_single_mismatch();
    test_saturation();
    test_reset_midrun();
    test_start_held();
    test_halt_entry1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
